// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port, fixed-latency RAM between the CPU's
//            instruction-fetch (IF) and data-memory (DM) ports. Grants are
//            combinational in the issue cycle. Responses are registered
//            one-cycle pulses.
// Options  : MEM_ARB_ROUND_ROBIN_EN - when defined, conflicts alternate
//            between the ports. When undefined, DM always wins a conflict.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    // Cycles from the RAM address cycle to valid ram_rdata. Legal range 1..4.
    parameter int RAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch port (read only)
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // data memory port
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    // RAM side
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [2:0] c_LATENCY = 3'(RAM_LATENCY);

    state_t              r_state;
    logic [2:0]          r_cnt;
    logic                r_owner_dm;
    logic                r_owner_we;
    logic                r_if_rvalid;
    logic                r_dm_rvalid;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;

    logic                w_issue;
    logic                w_conflict;
    logic                w_dm_wins_conflict;
    logic                w_pick_dm;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Set when IF lost the last conflict and so owns the next one.
    logic                r_rr_if_next;

    assign w_dm_wins_conflict = ~r_rr_if_next;

    // Hand the next conflict to whichever port lost this one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_if_next <= 1'b0;
        end else if (w_conflict) begin
            r_rr_if_next <= w_pick_dm;
        end
    end
`else
    assign w_dm_wins_conflict = 1'b1;
`endif

    // Issue only from IDLE. Reset blocks any grant so no RAM write can leak out.
    assign w_issue    = ~rst && (r_state == ST_IDLE) && (if_req || dm_req);
    assign w_conflict = w_issue && if_req && dm_req;
    assign w_pick_dm  = dm_req && (!if_req || w_dm_wins_conflict);

    // Winner's grant and RAM command are driven only in the issue cycle.
    always_comb begin
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (w_issue) begin
            if (w_pick_dm) begin
                dm_gnt    = 1'b1;
                ram_addr  = dm_addr;
                ram_we    = dm_we;
                ram_wdata = dm_wdata;
            end else begin
                if_gnt    = 1'b1;
                ram_addr  = if_addr;
            end
        end
    end

    // Access sequencer: latch the owner at issue, count down the RAM latency,
    // then capture the read data and pulse the owner's rvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_owner_dm  <= 1'b0;
            r_owner_we  <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_owner_dm <= w_pick_dm;
                        r_owner_we <= w_pick_dm && dm_we;
                        r_cnt      <= c_LATENCY;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 3'd1) begin
                        // ram_rdata is valid in this cycle
                        r_cnt   <= 3'd0;
                        r_state <= ST_IDLE;
                        if (r_owner_dm) begin
                            r_dm_rvalid <= 1'b1;
                            r_dm_rdata  <= r_owner_we ? '0 : ram_rdata;
                        end else begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= ram_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign dm_rvalid = r_dm_rvalid;
    assign dm_rdata  = r_dm_rdata;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, fixed-latency RAM between the CPU's instruction-fetch port (IF) and data-memory port (DM). It arbitrates requests, sequences each RAM access through a small state machine and returns registered responses. It sits between the core's fetch/load-store logic and the unified RAM. The core stalls on `*_gnt`/`*_rvalid`.

## Interface
- `ADDR_W`, 32, address width (byte address, passed through unchanged)
- `DATA_W`, 32, data width
- `RAM_LATENCY`, 1, cycles from RAM address cycle to valid `ram_rdata`; legal range 1..4
- `clk  in  1  clock; all state updates on rising edge`
- `rst  in  1  reset, synchronous, active-high`
- `if_req  in  1  fetch request (read only)`
- `if_addr  in  ADDR_W  fetch address`
- `if_gnt  out  1  fetch request accepted this cycle`
- `if_rvalid  out  1  one-cycle pulse: if_rdata valid`
- `if_rdata  out  DATA_W  fetched word`
- `dm_req  in  1  data request`
- `dm_we  in  1  1 = store, 0 = load`
- `dm_addr  in  ADDR_W  data address`
- `dm_wdata  in  DATA_W  store data`
- `dm_gnt  out  1  data request accepted this cycle`
- `dm_rvalid  out  1  one-cycle pulse: load data valid / store acknowledged`
- `dm_rdata  out  DATA_W  load data; 0 on store ack`
- `ram_addr  out  ADDR_W  RAM address`
- `ram_we  out  1  RAM write strobe`
- `ram_wdata  out  DATA_W  RAM write data`
- `ram_rdata  in  DATA_W  RAM read data`

## Operation
- FSM states: IDLE, WAIT.
- IDLE, no request: `ram_we`=0, `ram_addr`/`ram_wdata` = 0, both `*_gnt`=0.
- IDLE, request present: this is the issue cycle.
  - Select a winner: default policy is DM over IF.
  - Assert the winner's `*_gnt` combinationally.
  - Drive `ram_addr`/`ram_we`/`ram_wdata` from the winner. `ram_we` = `dm_we` for DM and 0 for IF.
  - Latch the owner and load the countdown with `RAM_LATENCY`.
  - Go to WAIT.
- WAIT: decrement the countdown each cycle. `ram_we`=0 and both gnt=0.
- When the countdown reaches 1 (the cycle in which `ram_rdata` is valid):
  - Capture `ram_rdata` into the owner's rdata register, or capture 0 for a store.
  - Set the owner's rvalid for the next cycle.
  - Go to IDLE.
- Requesters hold req/addr/we/wdata stable until gnt. After gnt they may drop req or present the next request.
- A loser keeps req high. It is granted in a later IDLE cycle, with no loss.
- `*_rdata` holds its last value until that port's next response.
- `*_gnt` is never asserted while req is low.
- `if_gnt` and `dm_gnt` are never both 1.

## Timing
- Issue at cycle t:
  - `*_gnt`=1 at t.
  - RAM data sampled at end of cycle t+RAM_LATENCY.
  - `*_rvalid`=1 for exactly cycle t+RAM_LATENCY+1.
- The next issue may occur at t+RAM_LATENCY+1, the same cycle as the rvalid pulse. Peak throughput is one access per RAM_LATENCY+1 cycles.
- Reset values:
  - All outputs 0, including both rdata registers.
  - FSM in IDLE, countdown 0.
  - Round-robin pointer set so the first conflict goes to DM.
- Reset mid-transaction: the access is abandoned and no rvalid is produced. Reset in a cycle where rvalid would rise suppresses it. `ram_we`=0 during reset.
- A request arriving in WAIT is not granted until the state returns to IDLE.
- Counter is 3 bits wide. RAM_LATENCY=1 gives exactly one WAIT cycle.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On a conflict (both req=1 in IDLE), the winner is the port that lost the previous conflict.
  - A 1-bit pointer updates only on conflicts.
  - Non-conflict grants leave the pointer untouched.
- Undefined: DM always wins conflicts and no pointer exists.

## Test plan
- Reset, then `if_req`=1, `if_addr`=0x100, RAM_LATENCY=2, `ram_rdata`=0xDEADBEEF at sample cycle → `if_gnt` at t, `if_rvalid`=1 with `if_rdata`=0xDEADBEEF at t+3 only.
- `dm_req`=1, `dm_we`=1, `dm_addr`=0x200, `dm_wdata`=0x12345678 → `ram_we`=1 with that address/data for exactly the issue cycle; `dm_rvalid`=1, `dm_rdata`=0 at t+RAM_LATENCY+1.
- Both req held, RAM_LATENCY=1, no macro → DM granted at t0, t2, t4…; IF never granted while `dm_req` stays high. With macro → grants alternate DM, IF, DM, IF; both rvalids pulse in order.
- Back-to-back: IF load issued at t, DM req present from t+1 → `dm_gnt` exactly at t+RAM_LATENCY+1, coinciding with `if_rvalid`.
- `rst`=1 at t+1 after a grant at t (RAM_LATENCY=3) → no rvalid ever; all outputs 0 from t+2. A new `if_req` after reset is granted normally.
